// File: rtl/controlador_ula8bits_pkg.sv
// Shared constants for the ALU logic unit and its sequential front-end:
// operand/opcode widths, supported opcodes and controller state encodings.
package controlador_ula8bits_pkg;

    localparam int unsigned LARGURA_PADRAO     = 8;
    localparam int unsigned CODIGO_BITS_PADRAO = 4;

    localparam logic [3:0] CODIGO_NOT  = 4'b0111;
    localparam logic [3:0] CODIGO_AND  = 4'b1000;
    localparam logic [3:0] CODIGO_OR   = 4'b1001;
    localparam logic [3:0] CODIGO_XOR  = 4'b1010;
    localparam logic [3:0] CODIGO_XNOR = 4'b1011;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        EXECUTA   = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

endpackage

// File: rtl/controlador_ula8bits_codigo_valido.sv
// Combinational opcode check: 1 when the code is one the logic unit supports.
module codigo_valido_ula
    import controlador_ula8bits_pkg::*;
#(
    parameter int unsigned CODIGO_BITS = CODIGO_BITS_PADRAO
) (
    input  logic [CODIGO_BITS-1:0] codigo,
    output logic                   valido_c
);

    always_comb begin
        valido_c = 1'b0;
        if ((codigo == CODIGO_BITS'(CODIGO_NOT)) ||
            (codigo == CODIGO_BITS'(CODIGO_AND)) ||
            (codigo == CODIGO_BITS'(CODIGO_OR))  ||
            (codigo == CODIGO_BITS'(CODIGO_XOR)) ||
            (codigo == CODIGO_BITS'(CODIGO_XNOR)))
            valido_c = 1'b1;
    end

endmodule

// File: rtl/controlador_ula8bits.sv
// Front-end for the 8-bit ALU logic unit: latches a command, presents it to the
// unit, captures its 9-bit result one cycle later and keeps a chaining accumulator.
module controlador_ula8bits
    import controlador_ula8bits_pkg::*;
#(
    parameter int unsigned LARGURA     = LARGURA_PADRAO,
    parameter int unsigned CODIGO_BITS = CODIGO_BITS_PADRAO
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   comandoValido,
    output logic                   comandoPronto,
    input  logic [CODIGO_BITS-1:0] comandoCodigo,
    input  logic [LARGURA-1:0]     comandoA,
    input  logic [LARGURA-1:0]     comandoB,
    input  logic                   usaAcumulador,
    output logic [LARGURA-1:0]     ulaEntradaA,
    output logic [LARGURA-1:0]     ulaEntradaB,
    output logic [CODIGO_BITS-1:0] ulaCodigo,
    input  logic [LARGURA:0]       ulaSaida,
    output logic                   resultadoValido,
    input  logic                   resultadoPronto,
    output logic [LARGURA:0]       resultado,
    output logic                   flagZero,
    output logic                   erroCodigo,
    output logic [LARGURA-1:0]     acumulador
);

    estado_t estado;
    logic    codigoValido;

    codigo_valido_ula #(
        .CODIGO_BITS (CODIGO_BITS)
    ) uCodigoValido (
        .codigo   (ulaCodigo),
        .valido_c (codigoValido)
    );

    // comandoPronto/resultadoValido are registered copies of the next-state decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= OCIOSO;
            comandoPronto   <= 1'b1;
            resultadoValido <= 1'b0;
            ulaEntradaA     <= '0;
            ulaEntradaB     <= '0;
            ulaCodigo       <= '0;
            resultado       <= '0;
            flagZero        <= 1'b0;
            erroCodigo      <= 1'b0;
            acumulador      <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (comandoValido) begin
                        ulaEntradaA   <= usaAcumulador ? acumulador : comandoA;
                        ulaEntradaB   <= comandoB;
                        ulaCodigo     <= comandoCodigo;
                        comandoPronto <= 1'b0;
                        estado        <= EXECUTA;
                    end
                end
                EXECUTA: begin
                    resultado       <= ulaSaida;
                    acumulador      <= ulaSaida[LARGURA-1:0];
                    flagZero        <= (ulaSaida[LARGURA-1:0] == '0);
                    erroCodigo      <= ~codigoValido;
                    resultadoValido <= 1'b1;
                    estado          <= RESULTADO;
                end
                RESULTADO: begin
                    // Return to idle only; a command seen in this cycle is not taken.
                    if (resultadoPronto) begin
                        resultadoValido <= 1'b0;
                        comandoPronto   <= 1'b1;
                        estado          <= OCIOSO;
                    end
                end
                default: begin
                    resultadoValido <= 1'b0;
                    comandoPronto   <= 1'b1;
                    estado          <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_ula8bits.sv
// Directed-vector bench for controlador_ula8bits with a behavioural logic unit beside it.
module tb_controlador_ula8bits;

    logic       clock = 1'b0;
    logic       reset;
    logic       comandoValido;
    logic       comandoPronto;
    logic [3:0] comandoCodigo;
    logic [7:0] comandoA;
    logic [7:0] comandoB;
    logic       usaAcumulador;
    logic [7:0] ulaEntradaA;
    logic [7:0] ulaEntradaB;
    logic [3:0] ulaCodigo;
    logic [8:0] ulaSaida;
    logic       resultadoValido;
    logic       resultadoPronto;
    logic [8:0] resultado;
    logic       flagZero;
    logic       erroCodigo;
    logic [7:0] acumulador;

    int nVetores = 0;
    int nErros   = 0;

    always #5 clock = ~clock;

    controlador_ula8bits dut (
        .clock           (clock),
        .reset           (reset),
        .comandoValido   (comandoValido),
        .comandoPronto   (comandoPronto),
        .comandoCodigo   (comandoCodigo),
        .comandoA        (comandoA),
        .comandoB        (comandoB),
        .usaAcumulador   (usaAcumulador),
        .ulaEntradaA     (ulaEntradaA),
        .ulaEntradaB     (ulaEntradaB),
        .ulaCodigo       (ulaCodigo),
        .ulaSaida        (ulaSaida),
        .resultadoValido (resultadoValido),
        .resultadoPronto (resultadoPronto),
        .resultado       (resultado),
        .flagZero        (flagZero),
        .erroCodigo      (erroCodigo),
        .acumulador      (acumulador)
    );

    // Logic unit model: bitwise ops, bit 8 always 0, unsupported codes give 0.
    always_comb begin
        ulaSaida = 9'h000;
        case (ulaCodigo)
            4'b0111: ulaSaida = {1'b0, ~ulaEntradaA};
            4'b1000: ulaSaida = {1'b0, ulaEntradaA & ulaEntradaB};
            4'b1001: ulaSaida = {1'b0, ulaEntradaA | ulaEntradaB};
            4'b1010: ulaSaida = {1'b0, ulaEntradaA ^ ulaEntradaB};
            4'b1011: ulaSaida = {1'b0, ~(ulaEntradaA ^ ulaEntradaB)};
            default: ulaSaida = 9'h000;
        endcase
    end

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        nVetores++;
        if (obs !== esp) begin
            nErros++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, esp);
        end
    endtask

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    // Offer a command in OCIOSO and check acceptance plus the 2-edge result latency.
    task automatic enviaComando(input logic [3:0] cod, input logic [7:0] a, input logic [7:0] b,
                                input logic usa, input logic [7:0] espA);
        confere("pronto_antes", 32'(comandoPronto), 32'd1);
        comandoCodigo = cod;
        comandoA      = a;
        comandoB      = b;
        usaAcumulador = usa;
        comandoValido = 1'b1;
        passo();
        comandoValido = 1'b0;
        confere("pronto_exec", 32'(comandoPronto), 32'd0);
        confere("valido_exec", 32'(resultadoValido), 32'd0);
        confere("ulaA", 32'(ulaEntradaA), 32'(espA));
        confere("ulaB", 32'(ulaEntradaB), 32'(b));
        confere("ulaCod", 32'(ulaCodigo), 32'(cod));
        passo();
        confere("valido_res", 32'(resultadoValido), 32'd1);
    endtask

    task automatic confereResultado(input logic [8:0] res, input logic fz, input logic erro,
                                    input logic [7:0] acc);
        confere("resultado", 32'(resultado), 32'(res));
        confere("flagZero", 32'(flagZero), 32'(fz));
        confere("erroCodigo", 32'(erroCodigo), 32'(erro));
        confere("acumulador", 32'(acumulador), 32'(acc));
    endtask

    task automatic liberaResultado();
        resultadoPronto = 1'b1;
        passo();
        resultadoPronto = 1'b0;
        confere("valido_liberado", 32'(resultadoValido), 32'd0);
        confere("pronto_liberado", 32'(comandoPronto), 32'd1);
    endtask

    initial begin
        reset           = 1'b1;
        comandoValido   = 1'b0;
        comandoCodigo   = 4'h0;
        comandoA        = 8'h00;
        comandoB        = 8'h00;
        usaAcumulador   = 1'b0;
        resultadoPronto = 1'b0;
        passo();
        passo();
        reset = 1'b0;

        confere("rst_pronto", 32'(comandoPronto), 32'd1);
        confere("rst_valido", 32'(resultadoValido), 32'd0);
        confere("rst_resultado", 32'(resultado), 32'd0);
        confere("rst_acc", 32'(acumulador), 32'd0);
        confere("rst_ulaA", 32'(ulaEntradaA), 32'd0);

        // 1: AND
        enviaComando(4'b1000, 8'hF0, 8'h3C, 1'b0, 8'hF0);
        confereResultado(9'h030, 1'b0, 1'b0, 8'h30);
        liberaResultado();

        // 2: XOR to zero, then NOT
        enviaComando(4'b1010, 8'hAA, 8'hAA, 1'b0, 8'hAA);
        confereResultado(9'h000, 1'b1, 1'b0, 8'h00);
        liberaResultado();
        enviaComando(4'b0111, 8'h0F, 8'h00, 1'b0, 8'h0F);
        confereResultado(9'h0F0, 1'b0, 1'b0, 8'hF0);
        confere("ula_hold_res", 32'(ulaEntradaA), 32'h0F);
        liberaResultado();
        confere("ula_hold_ocioso", 32'(ulaEntradaA), 32'h0F);
        confere("res_hold_ocioso", 32'(resultado), 32'h0F0);

        // 3: chaining through the accumulator; comandoA must be ignored
        enviaComando(4'b1001, 8'h01, 8'h02, 1'b0, 8'h01);
        confereResultado(9'h003, 1'b0, 1'b0, 8'h03);
        liberaResultado();
        enviaComando(4'b1010, 8'hFF, 8'h03, 1'b1, 8'h03);
        confereResultado(9'h000, 1'b1, 1'b0, 8'h00);
        liberaResultado();

        // 4: backpressure with a competing command held on the input
        enviaComando(4'b1000, 8'hFF, 8'h5A, 1'b0, 8'hFF);
        comandoCodigo = 4'b1001;
        comandoA      = 8'h0F;
        comandoB      = 8'hF0;
        usaAcumulador = 1'b0;
        comandoValido = 1'b1;
        for (int i = 0; i < 5; i++) begin
            passo();
            confere("bp_resultado", 32'(resultado), 32'h05A);
            confere("bp_pronto", 32'(comandoPronto), 32'd0);
            confere("bp_valido", 32'(resultadoValido), 32'd1);
        end
        confere("bp_ulaA", 32'(ulaEntradaA), 32'hFF);
        resultadoPronto = 1'b1;
        passo();
        resultadoPronto = 1'b0;
        confere("bp_volta_ocioso", 32'(comandoPronto), 32'd1);
        confere("bp_sem_aceite", 32'(ulaEntradaA), 32'hFF);
        passo();
        comandoValido = 1'b0;
        confere("bp_aceite", 32'(comandoPronto), 32'd0);
        confere("bp_novo_ulaA", 32'(ulaEntradaA), 32'h0F);
        passo();
        confere("bp_novo_valido", 32'(resultadoValido), 32'd1);
        confereResultado(9'h0FF, 1'b0, 1'b0, 8'hFF);
        liberaResultado();

        // 5: unsupported code, then a valid AND clears the error
        enviaComando(4'b0011, 8'hFF, 8'hFF, 1'b0, 8'hFF);
        confereResultado(9'h000, 1'b1, 1'b1, 8'h00);
        liberaResultado();
        enviaComando(4'b1000, 8'hC3, 8'h81, 1'b0, 8'hC3);
        confereResultado(9'h081, 1'b0, 1'b0, 8'h81);
        liberaResultado();

        // 6: reset while in EXECUTA aborts the operation
        comandoCodigo = 4'b1011;
        comandoA      = 8'h12;
        comandoB      = 8'h34;
        comandoValido = 1'b1;
        passo();
        comandoValido = 1'b0;
        confere("abort_exec", 32'(comandoPronto), 32'd0);
        reset = 1'b1;
        passo();
        reset = 1'b0;
        confere("abort_pronto", 32'(comandoPronto), 32'd1);
        confere("abort_valido", 32'(resultadoValido), 32'd0);
        confereResultado(9'h000, 1'b0, 1'b0, 8'h00);
        confere("abort_ulaA", 32'(ulaEntradaA), 32'd0);
        confere("abort_ulaCod", 32'(ulaCodigo), 32'd0);
        for (int i = 0; i < 4; i++) begin
            passo();
            confere("abort_sem_result", 32'(resultadoValido), 32'd0);
            confere("abort_acc", 32'(acumulador), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVetores, nErros);
        $finish;
    end

endmodule
